// File: rtl/mem_march_bist.sv
// March C- built-in self test for a single-port synchronous RAM.
// Handshake: start is a level sampled only in IDLE; done pulses once per completed run.
module mem_march_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M0    = 3'd1,
        M1    = 3'd2,
        M2    = 3'd3,
        M3    = 3'd4,
        M4    = 3'd5,
        M5    = 3'd6,
        DRAIN = 3'd7
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] P0 = '0;
    localparam logic [DATA_WIDTH-1:0] P1 = '1;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic                    wr_q, wr_n;

    // Operation decoded for the upcoming cycle, registered onto the RAM port.
    logic                    op_we, op_rd;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_data;

    logic                    rd_q;
    logic [DATA_WIDTH-1:0]   exp_q;
    logic                    cmp_vld;
    logic [DATA_WIDTH-1:0]   cmp_exp;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic                    mismatch;
    logic                    accept;

    assign dbg_state = state;
    assign accept    = (state == IDLE) && start;
    assign mismatch  = cmp_vld && (ram_rdata != cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            wr_q   <= wr_n;
        end
    end

    // M1-M4 spend a read cycle then a write cycle on each address; wr_q selects which.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wr_n    = 1'b0;
        unique case (state)
            IDLE: begin
                addr_n = '0;
                if (start) state_n = M0;
            end
            M0: begin
                if (addr_q == ADDR_LAST) begin
                    state_n = M1;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            M1, M2: begin
                if (!wr_q) begin
                    wr_n = 1'b1;
                end else if (addr_q == ADDR_LAST) begin
                    state_n = (state == M1) ? M2 : M3;
                    addr_n  = (state == M1) ? '0 : ADDR_LAST;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            M3, M4: begin
                if (!wr_q) begin
                    wr_n = 1'b1;
                end else if (addr_q == '0) begin
                    state_n = (state == M3) ? M4 : M5;
                    addr_n  = ADDR_LAST;
                end else begin
                    addr_n = addr_q - 1'b1;
                end
            end
            M5: begin
                if (addr_q == '0) begin
                    state_n = DRAIN;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_q - 1'b1;
                end
            end
            DRAIN: begin
                state_n = IDLE;
                addr_n  = '0;
            end
            default: begin
                state_n = IDLE;
                addr_n  = '0;
            end
        endcase
    end

    // op_data is the write data in write cycles and the expected read data otherwise.
    always_comb begin
        op_we   = 1'b0;
        op_rd   = 1'b0;
        op_addr = '0;
        op_data = P0;
        unique case (state_n)
            M0: begin
                op_we   = 1'b1;
                op_addr = addr_n;
                op_data = P0;
            end
            M1, M3: begin
                op_we   = wr_n;
                op_rd   = !wr_n;
                op_addr = addr_n;
                op_data = wr_n ? P1 : P0;
            end
            M2, M4: begin
                op_we   = wr_n;
                op_rd   = !wr_n;
                op_addr = addr_n;
                op_data = wr_n ? P0 : P1;
            end
            M5: begin
                op_rd   = 1'b1;
                op_addr = addr_n;
                op_data = P0;
            end
            default: begin
                op_we   = 1'b0;
                op_rd   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_q      <= 1'b0;
            exp_q     <= '0;
            busy      <= 1'b0;
            cmp_vld   <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
        end else begin
            ram_we    <= op_we;
            ram_addr  <= op_addr;
            ram_wdata <= op_we ? op_data : '0;
            rd_q      <= op_rd;
            exp_q     <= op_data;
            busy      <= (state_n != IDLE);
            cmp_vld   <= rd_q;
            cmp_exp   <= exp_q;
            cmp_addr  <= ram_addr;
        end
    end

    // err_count is still zero when the first mismatch of a run arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            done <= (state == DRAIN);
            if (accept) begin
                pass      <= 1'b0;
                err_count <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end else begin
                if (mismatch) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0) begin
                        fail_addr <= cmp_addr;
                        fail_data <= ram_rdata;
                    end
                end
                if (state == DRAIN) pass <= (err_count == 8'd0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench for mem_march_bist with a behavioural RAM that can inject
// a stuck-at bit or an address alias.
module tb_mem_march_bist;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [2:0]    dbg_state;

  mem_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data), .dbg_state(dbg_state)
  );

  // RAM model: 0 = good, 1 = addr 5 bit 3 stuck-at-0, 2 = addr bit 3 ignored
  int fault_mode = 0;
  logic [DW-1:0] mem [D];

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
    if (fault_mode == 2) return a & 4'b0111;
    return a;
  endfunction

  always @(posedge clk) begin
    ram_rdata <= mem[map_addr(ram_addr)];
    if (ram_we) begin
      if (fault_mode == 1 && ram_addr == 4'd5) mem[5] <= ram_wdata & 8'hF7;
      else mem[map_addr(ram_addr)] <= ram_wdata;
    end
  end

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in the first busy cycle; returns at the done negedge.
  task automatic watch_run(input bit op_checks, output int busy_cyc, output bit got_done);
    busy_cyc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy) begin
        if (op_checks) begin
          if (busy_cyc == 0) begin
            check_val("m0_first_we", ram_we, 1);
            check_val("m0_first_addr", ram_addr, 0);
            check_val("m0_first_wdata", ram_wdata, 0);
          end
          if (busy_cyc == 16) begin
            check_val("m1_read_we", ram_we, 0);
            check_val("m1_read_addr", ram_addr, 0);
          end
          if (busy_cyc == 17) begin
            check_val("m1_write_we", ram_we, 1);
            check_val("m1_write_addr", ram_addr, 0);
            check_val("m1_write_data", ram_wdata, 8'hFF);
          end
          if (busy_cyc == 80) begin
            check_val("m3_first_addr", ram_addr, 15);
            check_val("m3_first_we", ram_we, 0);
          end
          if (busy_cyc == 144) begin
            check_val("m5_first_addr", ram_addr, 15);
            check_val("m5_first_we", ram_we, 0);
          end
          if (busy_cyc == 159) check_val("m5_last_addr", ram_addr, 0);
          if (busy_cyc == 160) check_val("drain_we", ram_we, 0);
        end
        busy_cyc++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_one(input string tag, input int mode, input bit op_checks,
                         input logic [7:0] exp_err, input logic exp_pass,
                         input logic [AW-1:0] exp_faddr, input logic [DW-1:0] exp_fdata);
    int bc;
    bit gd;
    fault_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_busy_after_start"}, busy, 1);
    check_val({tag, "_err_cleared"}, err_count, 0);
    check_val({tag, "_pass_cleared"}, pass, 0);
    watch_run(op_checks, bc, gd);
    check_val({tag, "_busy_cycles"}, bc, 161);
    check_val({tag, "_done_seen"}, gd, 1);
    check_val({tag, "_pass"}, pass, exp_pass);
    check_val({tag, "_err_count"}, err_count, exp_err);
    check_val({tag, "_fail_addr"}, fail_addr, exp_faddr);
    check_val({tag, "_fail_data"}, fail_data, exp_fdata);
    repeat (3) @(negedge clk);
    check_val({tag, "_done_one_cycle"}, done, 0);
    check_val({tag, "_pass_held"}, pass, exp_pass);
    check_val({tag, "_err_held"}, err_count, exp_err);
    check_val({tag, "_idle_we"}, ram_we, 0);
    check_val({tag, "_idle_addr"}, ram_addr, 0);
  endtask

  initial begin
    int bc;
    bit gd;
    int n_done;
    int n_busy;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_pass", pass, 0);
    check_val("reset_err", err_count, 0);
    check_val("reset_faddr", fail_addr, 0);
    check_val("reset_fdata", fail_data, 0);
    check_val("reset_we", ram_we, 0);
    check_val("reset_addr", ram_addr, 0);
    check_val("reset_wdata", ram_wdata, 0);
    check_val("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_no_start", busy, 0);

    run_one("good", 0, 1'b1, 8'd0, 1'b1, 4'd0, 8'h00);
    run_one("stuck", 1, 1'b0, 8'd2, 1'b0, 4'd5, 8'hF7);
    run_one("alias", 2, 1'b1, 8'd32, 1'b0, 4'd8, 8'hFF);

    // reset in the middle of a run
    fault_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check_val("midrun_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrun_rst_busy", busy, 0);
    check_val("midrun_rst_we", ram_we, 0);
    check_val("midrun_rst_done", done, 0);
    check_val("midrun_rst_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check_val("midrun_no_done", n_done, 0);
    check_val("midrun_no_busy", n_busy, 0);
    check_val("midrun_pass_low", pass, 0);
    run_one("after_rst", 0, 1'b0, 8'd0, 1'b1, 4'd0, 8'h00);

    // start held high across a whole run
    start = 1'b1;
    @(negedge clk);
    check_val("held_busy", busy, 1);
    watch_run(1'b0, bc, gd);
    check_val("held_busy_cycles", bc, 161);
    check_val("held_done_seen", gd, 1);
    check_val("held_pass", pass, 1);
    @(negedge clk);
    check_val("held_rerun_busy", busy, 1);
    check_val("held_rerun_done_low", done, 0);
    check_val("held_rerun_pass_cleared", pass, 0);
    start = 1'b0;
    watch_run(1'b0, bc, gd);
    check_val("rerun_busy_cycles", bc, 161);
    check_val("rerun_done_seen", gd, 1);
    check_val("rerun_pass", pass, 1);
    check_val("rerun_err", err_count, 0);
    @(negedge clk);
    check_val("rerun_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_march_bist.md
MEM_MARCH_BIST -- requirements
Module: mem_march_bist

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of the RAM data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning width of the RAM address.
REQ-003 SHALL have parameter RAM_DEPTH, default 1 << ADDR_WIDTH, meaning number of words tested (D below).
REQ-004 SHALL have port clk  input  1  meaning sole clock, rising edge; one clock, all state on clk.
REQ-005 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  meaning request a test run; level, sampled only in IDLE.
REQ-007 SHALL have port ram_we  output  1  meaning write enable to the single-port synchronous RAM.
REQ-008 SHALL have port ram_addr  output  ADDR_WIDTH  meaning RAM address.
REQ-009 SHALL have port ram_wdata  output  DATA_WIDTH  meaning RAM write data.
REQ-010 SHALL have port ram_rdata  input  DATA_WIDTH  meaning RAM registered read data, valid the cycle after its address is presented (read-before-write on same edge).
REQ-011 SHALL have port busy  output  1  meaning test in progress.
REQ-012 SHALL have port done  output  1  meaning one-cycle pulse at end of run.
REQ-013 SHALL have port pass  output  1  meaning last completed run had zero mismatches.
REQ-014 SHALL have port err_count  output  8  meaning mismatch count of current/last run, saturating at 255.
REQ-015 SHALL have port fail_addr  output  ADDR_WIDTH  meaning address of first mismatch.
REQ-016 SHALL have port fail_data  output  DATA_WIDTH  meaning read data of first mismatch.

Function
REQ-017 SHALL implement FSM states IDLE, M0, M1, M2, M3, M4, M5, DRAIN; patterns P0 = all zeros, P1 = all ones.
REQ-018 SHALL run March C- elements: M0 up w0; M1 up (r0,w1); M2 up (r1,w0); M3 down (r0,w1); M4 down (r1,w0); M5 down r0; up = 0..D-1, down = D-1..0.
REQ-019 SHALL spend 1 cycle per address in M0 and M5 and 2 cycles per address (read cycle then write cycle, same ram_addr) in M1-M4.
REQ-020 SHALL move IDLE->M0 on the edge where start=1 in IDLE, clear err_count, pass, fail_addr, fail_data on that edge, and drive the first RAM op the next cycle.
REQ-021 SHALL advance to the next element after the last address of an element with no idle cycle; M5->DRAIN->IDLE.
REQ-022 SHALL compare ram_rdata against the pipelined expected pattern in the cycle after each read issue (DRAIN covers the final M5 read).
REQ-023 SHALL on each mismatch increment err_count (saturating at 255) and, on the first mismatch of a run only, load fail_addr with the read address and fail_data with ram_rdata.
REQ-024 SHALL hold busy=1 in M0..DRAIN: exactly 10*D+1 cycles (161 at defaults).
REQ-025 SHALL pulse done=1 for one cycle in the IDLE cycle following DRAIN and on that edge load pass = (err_count==0 including the DRAIN compare).
REQ-026 SHALL hold pass, err_count, fail_addr, fail_data stable from done until the next accepted start.
REQ-027 SHALL ignore start while busy; if start is still high in the done cycle, a new run is accepted on that edge.
REQ-028 SHALL drive ram_we=0, ram_addr=0, ram_wdata=0 whenever in IDLE; ram_we=1 only in write cycles.
REQ-029 SHALL register all outputs; no combinational path from ram_rdata to any output.

Reset
REQ-030 SHALL on rst_n=0 immediately force state IDLE and busy, done, pass, ram_we, ram_addr, ram_wdata, err_count, fail_addr, fail_data to 0.
REQ-031 SHALL on reset mid-run abort without a done pulse, leaving pass=0, and accept a new start only after rst_n returns high.

Verification
REQ-032 SHALL cover: reset asserted -> all outputs 0, ram_we=0 within the same cycle.
REQ-033 SHALL cover: fault-free RAM, 1-cycle start -> busy high 161 cycles, done pulse, pass=1, err_count=0.
REQ-034 SHALL cover: addr 5 bit 3 stuck-at-0 -> fails on r1 in M2 and M4: fail_addr=5, fail_data=8'hF7, err_count=2, pass=0.
REQ-035 SHALL cover: addr bit 3 ignored by RAM (aliasing) -> first mismatch M1 at addr 8: fail_addr=8, fail_data=8'hFF, pass=0.
REQ-036 SHALL cover: rst_n low at cycle 50 of a run -> busy=0, no done, pass=0; next start gives full 161-cycle run.
REQ-037 SHALL cover: start held high throughout -> pulses mid-run ignored; second run begins on the done edge, busy back high the next cycle.
